// File: rtl/rgmii_rx_decode.sv
// RGMII receive decode: turns the aligned rising/falling-edge samples of RXD
// and RX_CTL into a GMII-style byte stream with a byte strobe. In 10/100 mode
// it pairs nibbles low-first. In all modes it filters the in-band link status
// that the PHY sends during inter-frame gaps.
module rgmii_rx_decode #(
    parameter int unsigned STATUS_FILTER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [3:0] rxd_q1,
    input  logic [3:0] rxd_q2,
    input  logic       rx_ctl_q1,
    input  logic       rx_ctl_q2,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_valid,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_full_duplex
);

    localparam logic [7:0] FILT = 8'(STATUS_FILTER);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    phase_t     phase;
    logic [3:0] held_nib;
    logic       held_er;
    logic [1:0] speed_prev;
    logic       speed_seen;
    logic       frame_err;

    logic [3:0] stat_val;
    logic [7:0] stat_cnt;
    logic [7:0] stat_cnt_next;

    logic dv;
    logic er;
    logic gig;
    logic speed_chg;
    logic force_er;
    logic cand;

    // Per-cycle decode of the RX_CTL pair and of the mode / speed-change state.
    assign dv  = rx_ctl_q1;
    assign er  = rx_ctl_q1 ^ rx_ctl_q2;
    assign gig = speed[1];
    // The first cycle after reset has no previous speed to compare against.
    assign speed_chg = speed_seen && (speed != speed_prev);
    // A speed change mid-frame poisons the rest of that frame until dv falls.
    assign force_er  = dv && (speed_chg || frame_err);
    // Idle status is only trusted when both RXD edges agree.
    assign cand      = !dv && !er && (rxd_q1 == rxd_q2);

    // Next value of the status run counter.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        stat_cnt_next = 8'd0;
        if (cand) begin
            if (rxd_q1 == stat_val)
                stat_cnt_next = (stat_cnt == FILT) ? stat_cnt : stat_cnt + 8'd1;
            else
                stat_cnt_next = 8'd1;
        end
    end

    // Data path: byte pass-through at 1000M, nibble pairing at 10/100.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every register
            // sees the pre-edge values of the others, independent of order.
            phase         <= PH_LOW;
            held_nib      <= 4'h0;
            held_er       <= 1'b0;
            speed_prev    <= 2'b00;
            speed_seen    <= 1'b0;
            frame_err     <= 1'b0;
            gmii_rxd      <= 8'h00;
            gmii_rx_dv    <= 1'b0;
            gmii_rx_er    <= 1'b0;
            gmii_rx_valid <= 1'b0;
        end else begin
            speed_prev <= speed;
            speed_seen <= 1'b1;
            frame_err  <= force_er;
            if (gig) begin
                gmii_rxd      <= {rxd_q2, rxd_q1};
                gmii_rx_dv    <= dv;
                gmii_rx_er    <= er | force_er;
                gmii_rx_valid <= 1'b1;
                phase         <= PH_LOW;
                held_nib      <= 4'h0;
                held_er       <= 1'b0;
            end else if (phase == PH_HIGH && !speed_chg) begin
                // Second nibble (or dribble when dv has already fallen).
                gmii_rx_dv    <= 1'b1;
                gmii_rx_valid <= 1'b1;
                if (dv) begin
                    gmii_rxd   <= {rxd_q1, held_nib};
                    gmii_rx_er <= er | held_er | force_er;
                end else begin
                    gmii_rxd   <= {4'h0, held_nib};
                    gmii_rx_er <= 1'b1;
                end
                phase    <= PH_LOW;
                held_nib <= 4'h0;
                held_er  <= 1'b0;
            end else begin
                // Low phase, or a speed change just discarded the held nibble.
                gmii_rx_valid <= 1'b0;
                gmii_rx_dv    <= dv;
                gmii_rx_er    <= 1'b0;
                if (dv) begin
                    held_nib <= rxd_q1;
                    held_er  <= er | force_er;
                    phase    <= PH_HIGH;
                end else begin
                    held_nib <= 4'h0;
                    held_er  <= 1'b0;
                    phase    <= PH_LOW;
                end
            end
        end
    end

    // In-band status filter: publish a status once it has been seen
    // STATUS_FILTER times in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_val         <= 4'h0;
            stat_cnt         <= 8'd0;
            link_up          <= 1'b0;
            link_speed       <= 2'b00;
            link_full_duplex <= 1'b0;
        end else begin
            stat_cnt <= stat_cnt_next;
            if (cand)
                stat_val <= rxd_q1;
            if (stat_cnt_next == FILT) begin
                link_full_duplex <= rxd_q1[3];
                link_speed       <= rxd_q1[2:1];
                link_up          <= rxd_q1[0];
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Self-checking bench for rgmii_rx_decode: directed scenarios plus randomized
// frames and status streams checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_rgmii_rx_decode;

    localparam int F = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [3:0] rxd_q1, rxd_q2;
    logic       rx_ctl_q1, rx_ctl_q2;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, gmii_rx_valid;
    logic       link_up;
    logic [1:0] link_speed;
    logic       link_full_duplex;

    int checks   = 0;
    int failures = 0;

    logic       capture = 1'b0;
    logic [8:0] got_q[$];

    rgmii_rx_decode #(.STATUS_FILTER(F)) dut (
        .clk              (clk),
        .rst              (rst),
        .speed            (speed),
        .rxd_q1           (rxd_q1),
        .rxd_q2           (rxd_q2),
        .rx_ctl_q1        (rx_ctl_q1),
        .rx_ctl_q2        (rx_ctl_q2),
        .gmii_rxd         (gmii_rxd),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .gmii_rx_valid    (gmii_rx_valid),
        .link_up          (link_up),
        .link_speed       (link_speed),
        .link_full_duplex (link_full_duplex)
    );

    always #5 clk = ~clk;

    // Collect frame bytes (anything carrying dv or er) for the random test.
    always @(negedge clk) begin
        if (capture && !rst && gmii_rx_valid && (gmii_rx_dv || gmii_rx_er))
            got_q.push_back({gmii_rx_er, gmii_rxd});
    end

    // Apply one cycle of input, then look just after the sampling edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic c1, input logic c2);
        rxd_q1    = a;
        rxd_q2    = b;
        rx_ctl_q1 = c1;
        rx_ctl_q2 = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        speed = 2'b10;
        rxd_q1 = 4'h0; rxd_q2 = 4'h0; rx_ctl_q1 = 1'b0; rx_ctl_q2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, link_up, link_speed, link_full_duplex} !== 15'h0) begin
            failures++;
            $display("FAIL reset_state: got rxd=%h dv=%b er=%b valid=%b link=%b spd=%b fd=%b, want all zero",
                     gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, link_up, link_speed, link_full_duplex);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(6);
    endtask

    task automatic test_gig_preamble();
        logic [7:0] bytes [12];
        bytes = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                  8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 12; i++) begin
            step(bytes[i][3:0], bytes[i][7:4], 1'b1, 1'b1);
            checks++;
            if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, bytes[i]}) begin
                failures++;
                $display("FAIL gig_byte%0d: got v/dv/er=%b%b%b rxd=%h, want 110 rxd=%h",
                         i, gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd, bytes[i]);
            end
        end
        step(4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er} !== 3'b100) begin
            failures++;
            $display("FAIL gig_idle: got v/dv/er=%b%b%b, want 100", gmii_rx_valid, gmii_rx_dv, gmii_rx_er);
        end
    endtask

    task automatic test_100m();
        logic [3:0] nib [6];
        logic [7:0] exp [3];
        nib = '{4'h5, 4'h5, 4'hD, 4'h5, 4'h3, 4'hA};
        exp = '{8'h55, 8'h5D, 8'hA3};
        speed = 2'b01;
        idle(2);
        for (int i = 0; i < 6; i++) begin
            step(nib[i], 4'($urandom), 1'b1, 1'b1);
            checks++;
            if (i % 2 == 1) begin
                if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, exp[i/2]}) begin
                    failures++;
                    $display("FAIL m100_byte%0d: got v/dv/er=%b%b%b rxd=%h, want 110 rxd=%h",
                             i/2, gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd, exp[i/2]);
                end
            end else if (gmii_rx_valid !== 1'b0) begin
                failures++;
                $display("FAIL m100_gap%0d: got valid=%b, want 0", i, gmii_rx_valid);
            end
        end
        step(4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (gmii_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL m100_idle: got valid=%b, want 0", gmii_rx_valid);
        end
    endtask

    task automatic test_10m_dribble();
        speed = 2'b00;
        idle(2);
        step(4'h1, 4'h9, 1'b1, 1'b1);
        checks++;
        if (gmii_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL drib_first: got valid=%b, want 0", gmii_rx_valid);
        end
        step(4'h2, 4'h9, 1'b1, 1'b1);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, 8'h21}) begin
            failures++;
            $display("FAIL drib_pair: got v/dv/er=%b%b%b rxd=%h, want 110 rxd=21",
                     gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd);
        end
        step(4'h3, 4'h9, 1'b1, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b111, 8'h03}) begin
            failures++;
            $display("FAIL drib_odd: got v/dv/er=%b%b%b rxd=%h, want 111 rxd=03",
                     gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd);
        end
        step(4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (gmii_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL drib_after: got valid=%b, want 0", gmii_rx_valid);
        end
    endtask

    task automatic test_errors();
        speed = 2'b10;
        idle(2);
        step(4'h7, 4'h3, 1'b1, 1'b0);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b111, 8'h37}) begin
            failures++;
            $display("FAIL err_byte: got v/dv/er=%b%b%b rxd=%h, want 111 rxd=37",
                     gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd);
        end
        step(4'hE, 4'hE, 1'b0, 1'b1);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b101, 8'hEE}) begin
            failures++;
            $display("FAIL false_carrier: got v/dv/er=%b%b%b rxd=%h, want 101 rxd=EE",
                     gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd);
        end
        idle(6);
    endtask

    task automatic test_status();
        for (int i = 0; i < 3; i++) begin
            step(4'hD, 4'hD, 1'b0, 1'b0);
            checks++;
            if (link_up !== 1'b0) begin
                failures++;
                $display("FAIL status_early%0d: got link_up=%b, want 0", i, link_up);
            end
        end
        step(4'h5, 4'h5, 1'b1, 1'b1);
        checks++;
        if (link_up !== 1'b0) begin
            failures++;
            $display("FAIL status_dv: got link_up=%b, want 0", link_up);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'hD, 4'hD, 1'b0, 1'b0);
            checks++;
            if (i < 3) begin
                if ({link_full_duplex, link_speed, link_up} !== 4'b0000) begin
                    failures++;
                    $display("FAIL status_hold%0d: got fd/spd/up=%b%b%b, want 0000",
                             i, link_full_duplex, link_speed, link_up);
                end
            end else if ({link_full_duplex, link_speed, link_up} !== 4'b1101) begin
                failures++;
                $display("FAIL status_update: got fd/spd/up=%b%b%b, want 1101",
                         link_full_duplex, link_speed, link_up);
            end
        end
    endtask

    // Reference: link status equals the last candidate value that occurred
    // F times in an uninterrupted row of identical idle samples.
    task automatic test_status_random();
        logic [3:0] exp_status = 4'b1101;
        logic [3:0] last = 4'h0;
        logic [3:0] val  = 4'h3;
        int run = 0;
        int kind;
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) val = 4'($urandom);
            if (kind == 0) begin
                step(val, val, 1'b1, 1'b1);
                run = 0;
            end else if (kind == 1) begin
                step(val, val, 1'b0, 1'b1);
                run = 0;
            end else if (kind == 2) begin
                step(val, val ^ 4'($urandom_range(1, 15)), 1'b0, 1'b0);
                run = 0;
            end else begin
                step(val, val, 1'b0, 1'b0);
                run  = (run > 0 && val == last) ? run + 1 : 1;
                last = val;
                if (run == F) exp_status = val;
            end
            checks++;
            if ({link_full_duplex, link_speed, link_up} !== exp_status) begin
                failures++;
                $display("FAIL status_rand%0d: got fd/spd/up=%b%b%b, want %b",
                         n, link_full_duplex, link_speed, link_up, exp_status);
            end
        end
    endtask

    // Reference: bytes are consecutive nibble pairs low-first (er if either
    // nibble had er); an odd leftover becomes {0, nibble} with er set.
    task automatic test_random_frames();
        logic [8:0] exp_q[$];
        logic [1:0] modes [3];
        logic [7:0] b;
        logic [3:0] n, lo;
        logic       e, lo_e;
        int         len;
        modes = '{2'b10, 2'b01, 2'b00};
        for (int m = 0; m < 3; m++) begin
            speed = modes[m];
            idle(3);
            got_q.delete();
            exp_q.delete();
            capture = 1'b1;
            for (int f = 0; f < 8; f++) begin
                if (modes[m][1]) begin
                    len = $urandom_range(1, 10);
                    for (int k = 0; k < len; k++) begin
                        b = 8'($urandom);
                        e = ($urandom_range(0, 7) == 0);
                        step(b[3:0], b[7:4], 1'b1, !e);
                        exp_q.push_back({e, b});
                    end
                end else begin
                    len = $urandom_range(1, 13);
                    lo = 4'h0;
                    lo_e = 1'b0;
                    for (int k = 0; k < len; k++) begin
                        n = 4'($urandom);
                        e = ($urandom_range(0, 7) == 0);
                        step(n, 4'($urandom), 1'b1, !e);
                        if (k % 2 == 0) begin
                            lo = n;
                            lo_e = e;
                        end else begin
                            exp_q.push_back({e | lo_e, n, lo});
                        end
                    end
                    if (len % 2 == 1) exp_q.push_back({1'b1, 4'h0, lo});
                end
                repeat ($urandom_range(1, 3)) step(4'($urandom), 4'($urandom), 1'b0, 1'b0);
            end
            idle(2);
            capture = 1'b0;
            checks++;
            if (got_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand_count mode%0d: got %0d bytes, want %0d", m, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_byte mode%0d idx%0d: got er/rxd=%h, want %h", m, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_speed_change();
        speed = 2'b01;
        idle(2);
        step(4'h1, 4'h0, 1'b1, 1'b1);
        step(4'h2, 4'h0, 1'b1, 1'b1);
        checks++;
        if ({gmii_rx_valid, gmii_rx_er, gmii_rxd} !== {2'b10, 8'h21}) begin
            failures++;
            $display("FAIL spd_before: got v/er=%b%b rxd=%h, want 10 rxd=21", gmii_rx_valid, gmii_rx_er, gmii_rxd);
        end
        step(4'h3, 4'h0, 1'b1, 1'b1);
        speed = 2'b00;
        step(4'h4, 4'h0, 1'b1, 1'b1);
        checks++;
        if (gmii_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL spd_drop: got valid=%b rxd=%h, want valid=0 (held nibble discarded)", gmii_rx_valid, gmii_rxd);
        end
        step(4'h5, 4'h0, 1'b1, 1'b1);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b111, 8'h54}) begin
            failures++;
            $display("FAIL spd_err1: got v/dv/er=%b%b%b rxd=%h, want 111 rxd=54",
                     gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd);
        end
        step(4'h6, 4'h0, 1'b1, 1'b1);
        step(4'h7, 4'h0, 1'b1, 1'b1);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b111, 8'h76}) begin
            failures++;
            $display("FAIL spd_err2: got v/dv/er=%b%b%b rxd=%h, want 111 rxd=76",
                     gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd);
        end
        idle(2);
        step(4'h8, 4'h0, 1'b1, 1'b1);
        step(4'h9, 4'h0, 1'b1, 1'b1);
        checks++;
        if ({gmii_rx_valid, gmii_rx_er, gmii_rxd} !== {2'b10, 8'h98}) begin
            failures++;
            $display("FAIL spd_next_frame: got v/er=%b%b rxd=%h, want 10 rxd=98", gmii_rx_valid, gmii_rx_er, gmii_rxd);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_frame();
        speed = 2'b01;
        idle(2);
        step(4'h1, 4'h0, 1'b1, 1'b1);
        step(4'h2, 4'h0, 1'b1, 1'b1);
        step(4'h3, 4'h0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, link_up, link_speed, link_full_duplex} !== 15'h0) begin
            failures++;
            $display("FAIL async_reset: got rxd=%h dv=%b er=%b valid=%b link=%b spd=%b fd=%b, want all zero",
                     gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, link_up, link_speed, link_full_duplex);
        end
        rxd_q1 = 4'h0; rxd_q2 = 4'h0; rx_ctl_q1 = 1'b0; rx_ctl_q2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(4'hA, 4'h0, 1'b1, 1'b1);
        checks++;
        if (gmii_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_low: got valid=%b, want 0", gmii_rx_valid);
        end
        step(4'hB, 4'h0, 1'b1, 1'b1);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, 8'hBA}) begin
            failures++;
            $display("FAIL post_reset_byte: got v/dv/er=%b%b%b rxd=%h, want 110 rxd=BA",
                     gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_gig_preamble();
        test_100m();
        test_10m_dribble();
        test_errors();
        test_status();
        test_status_random();
        test_random_frames();
        test_speed_change();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
